// File: rtl/cheshire_board_pkg.sv
// Shared definitions for the Cheshire board control block.
//   - rst_state_e : SoC reset sequencer states (HOLD, RUN)
//   - Def*        : default values for the block's parameters
package cheshire_board_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_e;

  localparam int unsigned DefNumSw          = 4;
  localparam int unsigned DefBootModeW      = 2;
  localparam int unsigned DefDebounceCycles = 100000;
  localparam int unsigned DefRstHoldCycles  = 256;

endpackage

// File: rtl/cheshire_board_debounce.sv
// Single-bit two-flop synchroniser followed by a debounce cell.
// Ports:
//   clk_i  : board clock
//   rst_ni : asynchronous active-low reset
//   d_i    : raw, asynchronous input bit
//   q_o    : debounced level (changes only after DebounceCycles
//            consecutive synchronised cycles at the new level)
module cheshire_board_debounce
  import cheshire_board_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned     CntW   = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_d, sync_q;
  logic            stable_d, stable_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            synced;

  assign synced = sync_q[1];

  always_comb begin
    sync_d   = {sync_q[0], d_i};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // The new level has now been seen for DebounceCycles cycles in a row.
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_o = stable_q;

endmodule

// File: rtl/cheshire_board_ctrl.sv
// Board-level control for the Cheshire SoC: debounces the board switches,
// generates switch edge pulses, and sequences the SoC reset from the
// CPU_RESET push-button, latching boot/test mode at reset release.
// Ports:
//   clk_i, rst_ni    : board clock, asynchronous active-low reset
//   cpu_reset_i      : raw active-high reset push-button
//   sw_i             : raw general-purpose switches
//   boot_mode_i      : raw boot-mode switches
//   test_mode_i      : raw test-mode switch
//   sw_o             : debounced switch levels
//   sw_rise_o/fall_o : one-cycle pulses on debounced switch edges
//   boot_mode_o      : boot mode captured at SoC reset release
//   test_mode_o      : test mode captured at SoC reset release
//   soc_rst_no       : active-low SoC reset, released synchronously
//   rst_busy_o       : high while the SoC is held in reset
module cheshire_board_ctrl
  import cheshire_board_pkg::*;
#(
  parameter int unsigned NumSw          = DefNumSw,
  parameter int unsigned BootModeW      = DefBootModeW,
  parameter int unsigned DebounceCycles = DefDebounceCycles,
  parameter int unsigned RstHoldCycles  = DefRstHoldCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cpu_reset_i,
  input  logic [NumSw-1:0]     sw_i,
  input  logic [BootModeW-1:0] boot_mode_i,
  input  logic                 test_mode_i,
  output logic [NumSw-1:0]     sw_o,
  output logic [NumSw-1:0]     sw_rise_o,
  output logic [NumSw-1:0]     sw_fall_o,
  output logic [BootModeW-1:0] boot_mode_o,
  output logic                 test_mode_o,
  output logic                 soc_rst_no,
  output logic                 rst_busy_o
);

  if (DebounceCycles < 2) begin : g_bad_debounce
    $error("cheshire_board_ctrl: DebounceCycles must be at least 2");
  end
  if (RstHoldCycles < 1) begin : g_bad_hold
    $error("cheshire_board_ctrl: RstHoldCycles must be at least 1");
  end

  localparam int unsigned      NumIn   = NumSw + BootModeW + 2;
  localparam int unsigned      HoldW   = $clog2(RstHoldCycles + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(RstHoldCycles - 1);

  // Raw input bundle layout: {test_mode, cpu_reset, boot_mode, sw}
  logic [NumIn-1:0] raw_in, db_out;

  assign raw_in = {test_mode_i, cpu_reset_i, boot_mode_i, sw_i};

  for (genvar i = 0; i < NumIn; i++) begin : g_db
    cheshire_board_debounce #(
      .DebounceCycles(DebounceCycles)
    ) u_db (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (raw_in[i]),
      .q_o   (db_out[i])
    );
  end

  logic [NumSw-1:0]     sw_db;
  logic [BootModeW-1:0] boot_db;
  logic                 cpu_rst_db;
  logic                 test_db;

  assign sw_db      = db_out[NumSw-1:0];
  assign boot_db    = db_out[NumSw+BootModeW-1:NumSw];
  assign cpu_rst_db = db_out[NumSw+BootModeW];
  assign test_db    = db_out[NumIn-1];

  // Switch edge detection: pulses appear the cycle after sw_o changes.
  logic [NumSw-1:0] sw_prev_d, sw_prev_q;
  logic [NumSw-1:0] sw_rise_d, sw_rise_q;
  logic [NumSw-1:0] sw_fall_d, sw_fall_q;

  always_comb begin
    sw_prev_d = sw_db;
    sw_rise_d = sw_db & ~sw_prev_q;
    sw_fall_d = ~sw_db & sw_prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_prev_q <= '0;
      sw_rise_q <= '0;
      sw_fall_q <= '0;
    end else begin
      sw_prev_q <= sw_prev_d;
      sw_rise_q <= sw_rise_d;
      sw_fall_q <= sw_fall_d;
    end
  end

  assign sw_o      = sw_db;
  assign sw_rise_o = sw_rise_q;
  assign sw_fall_o = sw_fall_q;

  // Reset sequencer
  rst_state_e           state_d, state_q;
  logic [HoldW-1:0]     hold_cnt_d, hold_cnt_q;
  logic [BootModeW-1:0] boot_mode_d, boot_mode_q;
  logic                 test_mode_d, test_mode_q;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    boot_mode_d = boot_mode_q;
    test_mode_d = test_mode_q;
    case (state_q)
      ST_HOLD: begin
        if (cpu_rst_db) begin
          // Button still pressed: restart the minimum hold period.
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldMax) begin
          state_d     = ST_RUN;
          hold_cnt_d  = '0;
          boot_mode_d = boot_db;
          test_mode_d = test_db;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      ST_RUN: begin
        if (cpu_rst_db) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      boot_mode_q <= '0;
      test_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      boot_mode_q <= boot_mode_d;
      test_mode_q <= test_mode_d;
    end
  end

  assign soc_rst_no  = (state_q == ST_RUN);
  assign rst_busy_o  = (state_q == ST_HOLD);
  assign boot_mode_o = boot_mode_q;
  assign test_mode_o = test_mode_q;

endmodule

// File: tb/tb_cheshire_board_ctrl.sv
module tb_cheshire_board_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_reset;
  logic [3:0] sw;
  logic [1:0] boot;
  logic       test_mode;
  logic [3:0] sw_o, sw_rise, sw_fall;
  logic [1:0] boot_mode_o;
  logic       test_mode_o, soc_rst_no, rst_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cheshire_board_ctrl #(
    .NumSw         (4),
    .BootModeW     (2),
    .DebounceCycles(4),
    .RstHoldCycles (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cpu_reset_i(cpu_reset),
    .sw_i       (sw),
    .boot_mode_i(boot),
    .test_mode_i(test_mode),
    .sw_o       (sw_o),
    .sw_rise_o  (sw_rise),
    .sw_fall_o  (sw_fall),
    .boot_mode_o(boot_mode_o),
    .test_mode_o(test_mode_o),
    .soc_rst_no (soc_rst_no),
    .rst_busy_o (rst_busy)
  );

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic test_reset();
    rst_n = 1'b0; cpu_reset = 1'b0; sw = 4'b0000; boot = 2'b10; test_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL reset_soc_rst got %b want 0", soc_rst_no); end
    checks++; if (rst_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", rst_busy); end
    checks++; if (sw_o !== 4'b0000) begin errors++; $display("FAIL reset_sw got %b want 0000", sw_o); end
    checks++; if ({sw_rise, sw_fall} !== 8'h00) begin errors++; $display("FAIL reset_edges got %b want 0", {sw_rise, sw_fall}); end
    checks++; if (boot_mode_o !== 2'b00) begin errors++; $display("FAIL reset_boot got %b want 00", boot_mode_o); end
    checks++; if (test_mode_o !== 1'b0) begin errors++; $display("FAIL reset_test got %b want 0", test_mode_o); end
  endtask

  task automatic test_release();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (soc_rst_no !== (i == 8)) begin errors++; $display("FAIL release_soc_rst cyc %0d got %b want %b", i, soc_rst_no, (i == 8)); end
      checks++; if (rst_busy !== (i != 8)) begin errors++; $display("FAIL release_busy cyc %0d got %b want %b", i, rst_busy, (i != 8)); end
    end
    checks++; if (boot_mode_o !== 2'b10) begin errors++; $display("FAIL release_boot got %b want 10", boot_mode_o); end
    checks++; if (test_mode_o !== 1'b0) begin errors++; $display("FAIL release_test got %b want 0", test_mode_o); end
  endtask

  task automatic test_glitch();
    sw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) sw[0] = 1'b0;
      checks++; if ({sw_o[0], sw_rise[0], sw_fall[0]} !== 3'b000) begin errors++; $display("FAIL glitch cyc %0d got %b want 000", i, {sw_o[0], sw_rise[0], sw_fall[0]}); end
    end
  endtask

  task automatic test_debounce_edges();
    sw[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (sw_o[0] !== (i >= 6)) begin errors++; $display("FAIL rise_level cyc %0d got %b want %b", i, sw_o[0], (i >= 6)); end
      checks++; if ({sw_rise[0], sw_fall[0]} !== {(i == 7), 1'b0}) begin errors++; $display("FAIL rise_pulse cyc %0d got %b want %b", i, {sw_rise[0], sw_fall[0]}, {(i == 7), 1'b0}); end
    end
    sw[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (sw_o[0] !== (i < 6)) begin errors++; $display("FAIL fall_level cyc %0d got %b want %b", i, sw_o[0], (i < 6)); end
      checks++; if ({sw_rise[0], sw_fall[0]} !== {1'b0, (i == 7)}) begin errors++; $display("FAIL fall_pulse cyc %0d got %b want %b", i, {sw_rise[0], sw_fall[0]}, {1'b0, (i == 7)}); end
    end
  endtask

  task automatic test_boot_freeze();
    boot = 2'b01; test_mode = 1'b1; sw[3] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++; if ({boot_mode_o, test_mode_o, soc_rst_no} !== 4'b1001) begin errors++; $display("FAIL freeze cyc %0d got %b want 1001", i, {boot_mode_o, test_mode_o, soc_rst_no}); end
    end
    checks++; if (sw_o !== 4'b1000) begin errors++; $display("FAIL freeze_sw got %b want 1000", sw_o); end
  endtask

  task automatic test_cpu_reset();
    cpu_reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 20) cpu_reset = 1'b0;
      checks++; if (soc_rst_no !== (i <= 6)) begin errors++; $display("FAIL cpurst_hold cyc %0d got %b want %b", i, soc_rst_no, (i <= 6)); end
    end
    // Debounced release lands at cycle 6; RUN follows 8 cycles later.
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      checks++; if ({soc_rst_no, rst_busy} !== {(j == 14), (j != 14)}) begin errors++; $display("FAIL cpurst_release cyc %0d got %b want %b", j, {soc_rst_no, rst_busy}, {(j == 14), (j != 14)}); end
    end
    checks++; if ({boot_mode_o, test_mode_o} !== 3'b011) begin errors++; $display("FAIL cpurst_capture got %b want 011", {boot_mode_o, test_mode_o}); end
  endtask

  task automatic test_reset_abort();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++; if ({soc_rst_no, rst_busy} !== 2'b01) begin errors++; $display("FAIL abort_precount cyc %0d got %b want 01", i, {soc_rst_no, rst_busy}); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({soc_rst_no, rst_busy} !== 2'b01) begin errors++; $display("FAIL abort_rst got %b want 01", {soc_rst_no, rst_busy}); end
    checks++; if ({boot_mode_o, test_mode_o} !== 3'b000) begin errors++; $display("FAIL abort_modes got %b want 000", {boot_mode_o, test_mode_o}); end
    checks++; if ({sw_o, sw_rise, sw_fall} !== 12'h000) begin errors++; $display("FAIL abort_sw got %h want 000", {sw_o, sw_rise, sw_fall}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (soc_rst_no !== (i == 8)) begin errors++; $display("FAIL abort_restart cyc %0d got %b want %b", i, soc_rst_no, (i == 8)); end
    end
    checks++; if ({boot_mode_o, test_mode_o} !== 3'b011) begin errors++; $display("FAIL abort_capture got %b want 011", {boot_mode_o, test_mode_o}); end
    checks++; if (sw_o !== 4'b1000) begin errors++; $display("FAIL abort_sw_after got %b want 1000", sw_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_debounce_edges();
    test_boot_freeze();
    test_cpu_reset();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
